axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of AXI-Stream source ports; legal range 2..8.
REQ-002 Parameter DATA_W, default 8: tdata width in bits.
REQ-003 Port aclk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port aresetn, input, 1: synchronous, active-low reset.
REQ-005 Port s_tvalid, input, NUM_SRC: per-source valid.
REQ-006 Port s_tready, output, NUM_SRC: per-source ready.
REQ-007 Port s_tdata, input, NUM_SRC*DATA_W: source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 Port s_tlast, input, NUM_SRC: per-source end-of-packet flag.
REQ-009 Port m_tvalid, output, 1: merged stream valid.
REQ-010 Port m_tready, input, 1: downstream ready.
REQ-011 Port m_tdata, output, DATA_W: merged stream data.
REQ-012 Port m_tlast, output, 1: merged stream end-of-packet flag.
REQ-013 Port m_tid, output, $clog2(NUM_SRC): index of the source currently granted.

Function
REQ-014 The block SHALL have two states: IDLE (no grant) and BUSY (one source granted).
REQ-015 In IDLE: all s_tready = 0, m_tvalid = 0, m_tlast = 0 and m_tdata = 0.
REQ-016 In IDLE with any s_tvalid set, the block SHALL register a grant to the first requester found searching round-robin from (last_grant+1) mod NUM_SRC upward with wrap, then enter BUSY next cycle.
REQ-017 In BUSY:
  - m_tvalid, m_tdata and m_tlast SHALL combinationally follow the granted source.
  - s_tready[grant] = m_tready; all other s_tready = 0.
  - m_tid = grant.
REQ-018 A beat transfers when m_tvalid && m_tready.
REQ-019 A transferred beat with m_tlast = 1 SHALL return the state to IDLE on the next edge and update last_grant to the grant.
REQ-020 A grant SHALL be held for the whole packet; no re-arbitration occurs mid-packet, whatever other sources request.
REQ-021 Latency is one IDLE bubble cycle between packets, so at most one packet is transferred per (packet length + 1) cycles.
REQ-022 If the granted source drops s_tvalid in BUSY (protocol violation), the block SHALL hold BUSY and output m_tvalid = 0.
REQ-023 Requests arriving on the cycle the tlast beat transfers SHALL be considered only in the following IDLE cycle.
REQ-024 A single requester SHALL be re-granted immediately after each of its packets; no starvation: a continuously requesting source is granted within NUM_SRC-1 packets.
REQ-025 m_tid SHALL be 0 in IDLE.

Reset
REQ-026 With aresetn = 0 at an edge, the block SHALL enter IDLE and set last_grant = NUM_SRC-1, so that source 0 has first priority after reset.
REQ-027 Reset mid-packet SHALL abandon the packet with no further beats forwarded; the outputs SHALL take the IDLE values in the cycle after the reset edge.

Configuration
REQ-028 The macro AXIS_ARB_FORMAL_EN, when defined, SHALL compile in immediate assert statements for yosys formal checking:
  - exactly zero or one s_tready is high;
  - m_tid is stable while BUSY;
  - m_tdata and m_tlast are stable while m_tvalid && !m_tready;
  - the grant never changes except through IDLE.
REQ-029 Without AXIS_ARB_FORMAL_EN, no assertion logic SHALL be present, and the functional behaviour SHALL be identical.

Structure
REQ-030 A shared package/include axis_arb_pkg SHALL hold:
  - the state encoding constants (ST_IDLE = 1'b0, ST_BUSY = 1'b1);
  - the default widths.
REQ-031 The round-robin search SHALL live in one sub-module, axis_rr_pick: inputs req[NUM_SRC] and last[$clog2(NUM_SRC)]; outputs pick and any. It is purely combinational.
REQ-032 The top level contains the state register, the grant and last_grant registers, and the output muxes.

Verification
REQ-033 Reset, then only source 2 sends a 3-beat packet (tdata 19, 99, 1) with m_tready = 1 -> m_tid = 2; m_tdata 19, 99, 1 on consecutive cycles; m_tlast on the third beat; IDLE follows.
REQ-034 All four sources hold 2-beat packets from reset -> grant order 0, 1, 2, 3, 0; one idle cycle between packets.
REQ-035 Source 1 is mid-packet (beat 1 of 3 sent) when source 0 asserts valid -> source 1 finishes all 3 beats before source 0 is granted.
REQ-036 m_tready is held 0 for 4 cycles during a beat with tdata 244 -> m_tdata stays 244 and m_tvalid stays 1; the beat transfers on the first ready cycle.
REQ-037 aresetn is pulsed low during beat 2 of a 5-beat packet from source 3 -> next cycle all s_tready = 0 and m_tvalid = 0; the next grant goes to source 0 if it is requesting.
REQ-038 A single source 1 sends 10 back-to-back 1-beat packets (133, 209, ...) -> each is granted to 1, with throughput of one beat per 2 cycles; run under AXIS_ARB_FORMAL_EN with no assertion failure.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the round-robin AXI-Stream arbiter: state encoding and default widths.
package axis_arb_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   localparam int DEF_NUM_SRC = 4;
   localparam int DEF_DATA_W  = 8;

   typedef enum logic {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY
   } arb_state_e;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin search: first set bit of req starting just above last, wrapping.
module axis_rr_pick
   import axis_arb_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC
) (
   input  logic [NUM_SRC-1:0]         req,
   input  logic [$clog2(NUM_SRC)-1:0] last,
   output logic [$clog2(NUM_SRC)-1:0] pick,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_SRC);

   logic             found;
   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // Offsets 1..NUM_SRC visit every source once, ending on last itself.
   always_comb begin
      pick     = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand     = (int'(last) + k) % NUM_SRC;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            pick  = cand_idx;
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream packet arbiter: grant is held for a whole packet, one idle cycle between packets.
// Define AXIS_ARB_FORMAL_EN to compile in immediate assertions for formal checking.
module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [NUM_SRC-1:0]          s_tvalid,
   output logic [NUM_SRC-1:0]          s_tready,
   input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
   input  logic [NUM_SRC-1:0]          s_tlast,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic [DATA_W-1:0]           m_tdata,
   output logic                        m_tlast,
   output logic [$clog2(NUM_SRC)-1:0]  m_tid
);

   localparam int IDX_W = $clog2(NUM_SRC);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [IDX_W-1:0] pick;
   logic             pick_any;

   axis_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
      .req  (s_tvalid),
      .last (last_grant_q),
      .pick (pick),
      .any  (pick_any)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = BUSY;
               grant_d = pick;
            end
         end
         BUSY: begin
            if (m_tvalid && m_tready && m_tlast) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_SRC - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Outputs follow the granted source combinationally; everything is zero in IDLE.
   always_comb begin
      s_tready = '0;
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      m_tid    = '0;
      if (state_q == BUSY) begin
         m_tid = grant_q;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
               s_tready[i] = m_tready;
               m_tvalid    = s_tvalid[i];
               m_tdata     = s_tdata[i*DATA_W +: DATA_W];
               m_tlast     = s_tlast[i];
            end
         end
      end
   end

`ifdef AXIS_ARB_FORMAL_EN
   logic             fv_past_q;
   arb_state_e       fv_state_q;
   logic [IDX_W-1:0] fv_tid_q;
   logic [IDX_W-1:0] fv_grant_q;
   logic             fv_stall_q;
   logic [DATA_W-1:0] fv_tdata_q;
   logic             fv_tlast_q;

   // fv_past_q is low for the cycle following a reset edge, so history checks skip it.
   always_ff @(posedge aclk) begin
      fv_past_q  <= aresetn;
      fv_state_q <= state_q;
      fv_tid_q   <= m_tid;
      fv_grant_q <= grant_q;
      fv_stall_q <= m_tvalid && !m_tready;
      fv_tdata_q <= m_tdata;
      fv_tlast_q <= m_tlast;

      assert ($onehot0(s_tready));
      if (fv_past_q && fv_state_q == BUSY && state_q == BUSY) begin
         assert (m_tid == fv_tid_q);
         assert (grant_q == fv_grant_q);
      end
      if (fv_past_q && fv_stall_q && m_tvalid) begin
         assert (m_tdata == fv_tdata_q);
         assert (m_tlast == fv_tlast_q);
      end
   end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized and directed bench for axis_rr_arbiter, compared cycle by cycle against a packet-level model.
module tb_axis_rr_arbiter;

   localparam int NUM_SRC = 4;
   localparam int DATA_W  = 8;
   localparam int IDX_W   = $clog2(NUM_SRC);

   logic                      aclk = 1'b0;
   logic                      aresetn;
   logic [NUM_SRC-1:0]        s_tvalid;
   logic [NUM_SRC-1:0]        s_tready;
   logic [NUM_SRC*DATA_W-1:0] s_tdata;
   logic [NUM_SRC-1:0]        s_tlast;
   logic                      m_tvalid;
   logic                      m_tready;
   logic [DATA_W-1:0]         m_tdata;
   logic                      m_tlast;
   logic [IDX_W-1:0]          m_tid;

   always #5 aclk = ~aclk;

   axis_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tdata  (s_tdata),
      .s_tlast  (s_tlast),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tdata  (m_tdata),
      .m_tlast  (m_tlast),
      .m_tid    (m_tid)
   );

   // Each source holds a queue of beats {tlast, tdata}.
   logic [DATA_W:0]    srcq [NUM_SRC][$];
   int                 owner;
   int                 lastg;
   int                 cyc;
   int                 n_checks;
   int                 n_errors;
   logic               rstn_drv;
   logic               mready_drv;
   logic               chk_en;
   logic [NUM_SRC-1:0] en;
   int                 glog [$];
   int                 xlog [$];
   int                 dlog [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_beat(input int s, input int d, input bit l);
      logic [DATA_W-1:0] dv;
      dv = d[DATA_W-1:0];
      srcq[s].push_back({l, dv});
   endtask

   task automatic push_rand_pkt(input int s);
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) push_beat(s, $urandom_range(0, 255), b == len - 1);
   endtask

   // One clock cycle: drive at negedge, check after settling, advance the model for the coming edge.
   task automatic step();
      logic [NUM_SRC-1:0] exp_ready;
      logic               exp_valid;
      logic [DATA_W-1:0]  exp_data;
      logic               exp_last;
      int                 exp_tid;
      logic [DATA_W:0]    head;
      logic [DATA_W:0]    b;
      int                 c;
      @(negedge aclk);
      aresetn  = rstn_drv;
      m_tready = mready_drv;
      for (int i = 0; i < NUM_SRC; i++) begin
         head = (srcq[i].size() > 0) ? srcq[i][0] : '0;
         s_tvalid[i] = en[i] && (srcq[i].size() > 0);
         s_tdata[i*DATA_W +: DATA_W] = head[DATA_W-1:0];
         s_tlast[i] = head[DATA_W];
      end
      #1;
      exp_ready = '0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_last  = 1'b0;
      exp_tid   = 0;
      if (owner >= 0) begin
         head = (srcq[owner].size() > 0) ? srcq[owner][0] : '0;
         exp_ready[owner] = mready_drv;
         exp_valid = s_tvalid[owner];
         exp_data  = head[DATA_W-1:0];
         exp_last  = head[DATA_W];
         exp_tid   = owner;
      end
      if (chk_en) begin
         check_eq("s_tready", 32'(s_tready), 32'(exp_ready));
         check_eq("m_tvalid", 32'(m_tvalid), 32'(exp_valid));
         check_eq("m_tdata", 32'(m_tdata), 32'(exp_data));
         check_eq("m_tlast", 32'(m_tlast), 32'(exp_last));
         check_eq("m_tid", 32'(m_tid), exp_tid);
      end
      if (aresetn && m_tvalid && m_tready) dlog.push_back(int'(m_tdata));
      if (!rstn_drv) begin
         if (owner >= 0) begin
            b = '0;
            while (srcq[owner].size() > 0 && !b[DATA_W]) b = srcq[owner].pop_front();
         end
         owner = -1;
         lastg = NUM_SRC - 1;
      end else if (owner < 0) begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            c = (lastg + k) % NUM_SRC;
            if (owner < 0 && s_tvalid[c]) begin
               owner = c;
               glog.push_back(c);
            end
         end
      end else if (exp_valid && mready_drv) begin
         b = srcq[owner].pop_front();
         xlog.push_back(cyc);
         if (b[DATA_W]) begin
            lastg = owner;
            owner = -1;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
      en         = '1;
      mready_drv = 1'b1;
      rstn_drv   = 1'b0;
      step();
      rstn_drv   = 1'b1;
      glog.delete();
      xlog.delete();
      dlog.delete();
   endtask

   initial begin
      int exp34 [5];
      int c0;
      int guard;
      exp34 = '{0, 1, 2, 3, 0};
      owner = -1; lastg = NUM_SRC - 1; cyc = 0;
      n_checks = 0; n_errors = 0;
      chk_en = 1'b0;
      aresetn = 1'b0; m_tready = 1'b0; s_tvalid = '0; s_tdata = '0; s_tlast = '0;
      en = '1; mready_drv = 1'b1; rstn_drv = 1'b0;
      step();
      chk_en = 1'b1;
      do_reset();

      // Single source 2, three beats.
      push_beat(2, 19, 0); push_beat(2, 99, 0); push_beat(2, 1, 1);
      repeat (6) step();
      check_eq("r33_grant", glog[0], 2);
      check_eq("r33_beats", dlog.size(), 3);
      check_eq("r33_d0", dlog[0], 19);
      check_eq("r33_d1", dlog[1], 99);
      check_eq("r33_d2", dlog[2], 1);
      check_eq("r33_b2_cycle", xlog[2] - xlog[0], 2);

      // All four sources, 2-beat packets, plus a second packet on source 0.
      do_reset();
      for (int s = 0; s < NUM_SRC; s++) begin
         push_beat(s, 10 * s + 1, 0); push_beat(s, 10 * s + 2, 1);
      end
      push_beat(0, 7, 0); push_beat(0, 8, 1);
      repeat (20) step();
      check_eq("r34_npkts", glog.size(), 5);
      for (int i = 0; i < 5; i++) check_eq("r34_order", glog[i], exp34[i]);
      check_eq("r34_nbeats", xlog.size(), 10);
      check_eq("r34_span", xlog[9] - xlog[0], 13);

      // Source 0 arrives while source 1 is mid-packet.
      do_reset();
      push_beat(1, 11, 0); push_beat(1, 12, 0); push_beat(1, 13, 1);
      guard = 0;
      while (xlog.size() < 1 && guard < 20) begin step(); guard++; end
      check_eq("r35_first_beat", xlog.size(), 1);
      push_beat(0, 21, 0); push_beat(0, 22, 1);
      repeat (10) step();
      check_eq("r35_order1", glog[1], 0);
      check_eq("r35_d2", dlog[2], 13);
      check_eq("r35_d3", dlog[3], 21);

      // Four stall cycles on a beat.
      do_reset();
      push_beat(0, 244, 1);
      mready_drv = 1'b0;
      c0 = cyc;
      repeat (5) step();
      mready_drv = 1'b1;
      repeat (3) step();
      check_eq("r36_xfer_cycle", xlog[0], c0 + 5);
      check_eq("r36_data", dlog[0], 244);

      // Reset during beat 2 of a 5-beat packet from source 3.
      do_reset();
      en = 4'b1000;
      for (int b = 0; b < 5; b++) push_beat(3, 31 + b, b == 4);
      guard = 0;
      while (xlog.size() < 1 && guard < 20) begin step(); guard++; end
      check_eq("r37_first_beat", xlog.size(), 1);
      rstn_drv = 1'b0;
      step();
      rstn_drv = 1'b1;
      en = '1;
      push_beat(0, 41, 1);
      push_beat(1, 51, 1);
      repeat (8) step();
      check_eq("r37_regrant", glog[1], 0);
      check_eq("r37_no_beat2", dlog[1], 41);

      // Back-to-back single-beat packets from source 1.
      do_reset();
      for (int k = 0; k < 10; k++) push_beat(1, (133 + 76 * k) & 255, 1);
      repeat (25) step();
      check_eq("r38_npkts", glog.size(), 10);
      for (int k = 0; k < 10; k++) check_eq("r38_grant", glog[k], 1);
      for (int k = 1; k < 10; k++) check_eq("r38_spacing", xlog[k] - xlog[k-1], 2);
      check_eq("r38_d1", dlog[1], 209);

      // Random traffic, stalls, valid gaps and occasional resets.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int s = 0; s < NUM_SRC; s++)
            if (srcq[s].size() < 4 && $urandom_range(0, 7) == 0) push_rand_pkt(s);
         for (int s = 0; s < NUM_SRC; s++) en[s] = ($urandom_range(0, 9) != 0);
         mready_drv = ($urandom_range(0, 3) != 0);
         rstn_drv   = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
